// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-ported register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and the halt-dump stream.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NRD-1:0][AW-1:0]   rd_num;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NWR-1:0]           wr_we;
    logic [NWR-1:0][AW-1:0]   wr_num;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     halted;
    logic                     dump_valid;
    logic                     dump_ready;
    logic [AW-1:0]            dump_idx;
    logic [XLEN-1:0]          dump_data;
    logic                     dump_done;

    modport master (
        output rd_num, wr_we, wr_num, wr_data, halted, dump_ready,
        input  rd_data, dump_valid, dump_idx, dump_data, dump_done
    );

    modport slave (
        input  rd_num, wr_we, wr_num, wr_data, halted, dump_ready,
        output rd_data, dump_valid, dump_idx, dump_data, dump_done
    );

endinterface

// File: rtl/regfile_dump_fsm.sv
// Halt-triggered register dump sequencer: halted edge detect, IDLE/DUMP/DONE FSM, beat index.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     halted_i,
    input  logic                     dump_ready_i,
    output logic                     dump_valid_o,
    output logic                     dump_done_o,
    output logic [$clog2(DEPTH)-1:0] dump_idx_o,
    output logic                     wr_open_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    dump_state_t   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          halted_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            halted_q <= halted_i;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (halted_i && !halted_q) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                // Last index ends the dump instead of wrapping back to 0.
                if (dump_ready_i) begin
                    if (idx_q == AW'(DEPTH - 1)) state_d = DONE;
                    else                         idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (!halted_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign dump_valid_o = (state_q == DUMP);
    assign dump_done_o  = (state_q == DONE);
    assign dump_idx_o   = idx_q;
    assign wr_open_o    = (state_q == IDLE);

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with halt-triggered dump; r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
) (
    input logic         clk,
    input logic         rst_b,
    regfile_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] regs_q [DEPTH];
    logic [XLEN-1:0] regs_d [DEPTH];
    logic            wr_open;
    logic [AW-1:0]   dump_idx;

    regfile_dump_fsm #(.DEPTH(DEPTH)) u_dump (
        .clk          (clk),
        .rst_b        (rst_b),
        .halted_i     (bus.halted),
        .dump_ready_i (bus.dump_ready),
        .dump_valid_o (bus.dump_valid),
        .dump_done_o  (bus.dump_done),
        .dump_idx_o   (dump_idx),
        .wr_open_o    (wr_open)
    );

    // Ascending port order lets the highest-index port win an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr_open) begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (bus.wr_we[w] && (bus.wr_num[w] != '0))
                    regs_d[bus.wr_num[w]] = bus.wr_data[w];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            if (bus.rd_num[p] != '0) begin
                bus.rd_data[p] = regs_q[bus.rd_num[p]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned w = 0; w < NWR; w++) begin
                    if (wr_open && bus.wr_we[w] && (bus.wr_num[w] == bus.rd_num[p]))
                        bus.rd_data[p] = bus.wr_data[w];
                end
`endif
            end
        end
    end

    assign bus.dump_idx  = dump_idx;
    assign bus.dump_data = regs_q[dump_idx];

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter DEPTH, default 32, register count (power of two, >=2); AW = clog2(DEPTH).
REQ-003 Parameter NRD, default 2, read-port count (>=1).
REQ-004 Parameter NWR, default 1, write-port count (>=1).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_b  in  1  reset, asynchronous, active-low.
REQ-007 rd_num  in  NRD x AW  read addresses.
REQ-008 rd_data  out  NRD x XLEN  read data.
REQ-009 wr_we  in  NWR  per-port write enables.
REQ-010 wr_num  in  NWR x AW  write addresses.
REQ-011 wr_data  in  NWR x XLEN  write data.
REQ-012 halted  in  1  core halted; triggers register dump.
REQ-013 dump_valid  out  1  dump beat available.
REQ-014 dump_ready  in  1  consumer accepts beat.
REQ-015 dump_idx  out  AW  register index of current beat.
REQ-016 dump_data  out  XLEN  register contents of current beat.
REQ-017 dump_done  out  1  dump complete.

Function
REQ-018 Reads combinational, zero latency; rd_data[p] = reg[rd_num[p]]; address 0 always reads 0.
REQ-019 Write when wr_we[w] and wr_num[w]!=0 and FSM in IDLE; data visible to reads the next cycle; writes to address 0 discarded.
REQ-020 Multiple ports writing the same address in one cycle: highest-index port wins; others dropped.
REQ-021 Dump FSM states IDLE, DUMP, DONE; a halted 0->1 transition (registered halted_q vs halted) in IDLE -> DUMP with dump_idx=0.
REQ-022 In DUMP: dump_valid=1, dump_data=reg[dump_idx]; beat transfers when dump_valid && dump_ready; dump_idx increments by 1 per transfer.
REQ-023 dump_idx and dump_data held stable while dump_valid && !dump_ready.
REQ-024 Transfer of index DEPTH-1 -> DONE; no wrap to 0; exactly DEPTH beats per dump (index 0 beat carries 0).
REQ-025 DONE: dump_valid=0, dump_done=1; held until halted=0, then -> IDLE next cycle.
REQ-026 halted falling in DUMP: dump continues to completion, then DONE -> IDLE immediately since halted=0.
REQ-027 All write ports ignored in DUMP and DONE (architectural state frozen during dump).

Reset
REQ-028 rst_b low: all registers 0, FSM IDLE, dump_idx 0, halted_q 0, dump_valid 0, dump_done 0, immediately (asynchronous).
REQ-029 Reset mid-dump aborts the dump; no beats issued until a new halted rising edge.
REQ-030 halted already high when rst_b releases counts as a rising edge (halted_q resets to 0): dump starts first cycle after release.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: read of an address being written same cycle (nonzero, accepted per REQ-019/020) returns the winning wr_data combinationally.
REQ-032 Macro absent: reads return the pre-write stored value; no bypass logic present.

Structure
REQ-033 Package regfile_pkg holds dump_state_t enum (IDLE, DUMP, DONE) and default XLEN/DEPTH constants.
REQ-034 Dump FSM, index counter and halted edge detector in sub-module regfile_dump_fsm; storage and port logic in regfile_mp.

Verification
REQ-035 Write 0xDEADBEEF to r8 via port 0, read r8 next cycle on both read ports -> 0xDEADBEEF; write to r0 -> reads 0.
REQ-036 NWR=2, both ports write r5 (0x11, 0x22) same cycle -> r5=0x22.
REQ-037 Write r3=0xA5 while reading r3 same cycle -> 0xA5 with REGFILE_BYPASS_EN, prior value (0) without.
REQ-038 Preload r1..r31=i, pulse halted high, dump_ready=1 -> 32 beats idx 0..31, data 0,1..31, then dump_done=1; writes during dump ignored.
REQ-039 Dump with dump_ready toggling every other cycle -> idx/data stable while stalled, still 32 ordered beats.
REQ-040 Assert rst_b low at beat 10 -> outputs 0, registers 0; halted kept high through release -> fresh dump from idx 0.
